// File: rtl/obi_rr_arbiter_pkg.sv
// Shared constants and helpers for the OBI round-robin arbiter slice.
package obi_rr_arbiter_pkg;

    localparam int unsigned DefaultNumMgr         = 2;
    localparam int unsigned DefaultAddrWidth      = 32;
    localparam int unsigned DefaultDataWidth      = 32;
    localparam int unsigned DefaultMaxOutstanding = 2;

    // Increment an index and wrap it back to zero at the modulus.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO that remembers which manager owns each outstanding transaction.
module obi_id_fifo
    import obi_rr_arbiter_pkg::*;
#(
    parameter int unsigned Depth = DefaultMaxOutstanding,
    parameter int unsigned Width = 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                core_clk_i,
    input  logic                rstn_i,
    input  logic                push,
    input  logic                pop,
    input  logic [Width-1:0]    din,
    output logic [Width-1:0]    head,
    output logic [CntWidth-1:0] count
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                pop_eff;

    // Popping an empty FIFO is ignored so the occupancy can never underflow.
    assign pop_eff = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge core_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Wrap-around pointers and occupancy; push plus pop leaves the count unchanged.
    always_ff @(posedge core_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= PtrWidth'(wrap_inc(32'(wr_ptr_q), Depth));
            end
            if (pop_eff) begin
                rd_ptr_q <= PtrWidth'(wrap_inc(32'(rd_ptr_q), Depth));
            end
            if (push && !pop_eff) begin
                count_q <= count_q + CntWidth'(1);
            end else if (!push && pop_eff) begin
                count_q <= count_q - CntWidth'(1);
            end
        end
    end

    // The arbiter gates requests on occupancy, so a push into a full FIFO is a design bug.
    assert property (@(posedge core_clk_i) disable iff (!rstn_i)
        push |-> (count_q < CntWidth'(Depth)));

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate between several managers,
// with an ID FIFO routing in-order responses back to their owners.
module obi_rr_arbiter
    import obi_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumMgr         = DefaultNumMgr,
    parameter int unsigned AddrWidth      = DefaultAddrWidth,
    parameter int unsigned DataWidth      = DefaultDataWidth,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
    localparam int unsigned IdxWidth      = $clog2(NumMgr)
) (
    input  logic                                core_clk_i,
    input  logic                                rstn_i,
    input  logic [NumMgr-1:0]                   m_req_i,
    output logic [NumMgr-1:0]                   m_gnt_o,
    input  logic [NumMgr-1:0][AddrWidth-1:0]    m_addr_i,
    input  logic [NumMgr-1:0]                   m_we_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]    m_wdata_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]  m_be_i,
    output logic [NumMgr-1:0]                   m_rvalid_o,
    output logic [NumMgr-1:0][DataWidth-1:0]    m_rdata_o,
    output logic [NumMgr-1:0]                   m_err_o,
    output logic                                s_req_o,
    input  logic                                s_gnt_i,
    output logic [AddrWidth-1:0]                s_addr_o,
    output logic                                s_we_o,
    output logic [DataWidth-1:0]                s_wdata_o,
    output logic [DataWidth/8-1:0]              s_be_o,
    input  logic                                s_rvalid_i,
    input  logic [DataWidth-1:0]                s_rdata_i,
    input  logic                                s_err_i,
    output logic                                proto_err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    logic [IdxWidth-1:0] rr_q;
    logic                lock_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                proto_err_q;

    logic [IdxWidth-1:0] sel;
    logic                found;
    int unsigned         cand;
    logic                handshake;
    logic                resp_pop;
    logic                spurious;
    logic [IdxWidth-1:0] fifo_head;
    logic [CntWidth-1:0] fifo_count;

    // Pick the first requester at or after the rr pointer; a stalled address phase stays locked.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            cand = (32'(rr_q) + i) % NumMgr;
            if (!found && m_req_i[IdxWidth'(cand)]) begin
                sel   = IdxWidth'(cand);
                found = 1'b1;
            end
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    // Occupancy gating deliberately ignores a same-cycle pop so fullness is decided by state alone.
    assign s_req_o   = rstn_i && (|m_req_i) && (fifo_count < CntWidth'(MaxOutstanding));
    assign handshake = s_req_o && s_gnt_i;
    assign s_addr_o  = m_addr_i[sel];
    assign s_we_o    = m_we_i[sel];
    assign s_wdata_o = m_wdata_i[sel];
    assign s_be_o    = m_be_i[sel];

    assign resp_pop  = s_rvalid_i && (fifo_count != '0);
    assign spurious  = s_rvalid_i && (fifo_count == '0);
    assign m_rdata_o = {NumMgr{s_rdata_i}};
    assign proto_err_o = proto_err_q;

    // Only the selected manager sees the grant of a completed handshake.
    always_comb begin
        m_gnt_o = '0;
        if (handshake) begin
            m_gnt_o[sel] = 1'b1;
        end
    end

    // Route the response strobe and error to the owner at the FIFO head.
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        if (resp_pop) begin
            m_rvalid_o[fifo_head] = 1'b1;
            m_err_o[fifo_head]    = s_err_i;
        end
    end

    // Advance the rr pointer on handshake, hold a stalled selection, and latch protocol errors.
    always_ff @(posedge core_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q   <= IdxWidth'(wrap_inc(32'(sel), NumMgr));
                lock_q <= 1'b0;
            end else if (s_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (spurious) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    obi_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) u_id_fifo (
        .core_clk_i (core_clk_i),
        .rstn_i     (rstn_i),
        .push       (handshake),
        .pop        (resp_pop),
        .din        (sel),
        .head       (fifo_head),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_obi_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic                   core_clk_i;
    logic                   rstn_i;
    logic [NM-1:0]          m_req_i;
    logic [NM-1:0]          m_gnt_o;
    logic [NM-1:0][AW-1:0]  m_addr_i;
    logic [NM-1:0]          m_we_i;
    logic [NM-1:0][DW-1:0]  m_wdata_i;
    logic [NM-1:0][BW-1:0]  m_be_i;
    logic [NM-1:0]          m_rvalid_o;
    logic [NM-1:0][DW-1:0]  m_rdata_o;
    logic [NM-1:0]          m_err_o;
    logic                   s_req_o;
    logic                   s_gnt_i;
    logic [AW-1:0]          s_addr_o;
    logic                   s_we_o;
    logic [DW-1:0]          s_wdata_o;
    logic [BW-1:0]          s_be_o;
    logic                   s_rvalid_i;
    logic [DW-1:0]          s_rdata_i;
    logic                   s_err_i;
    logic                   proto_err_o;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: rr pointer, stall lock, owner queue, sticky error.
    int      mRr;
    bit      mLock;
    int      mLockIdx;
    int      mQ[$];
    bit      mProto;
    logic [NM-1:0] holdReq;

    obi_rr_arbiter #(
        .NumMgr         (NM),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .core_clk_i  (core_clk_i),
        .rstn_i      (rstn_i),
        .m_req_i     (m_req_i),
        .m_gnt_o     (m_gnt_o),
        .m_addr_i    (m_addr_i),
        .m_we_i      (m_we_i),
        .m_wdata_i   (m_wdata_i),
        .m_be_i      (m_be_i),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt_i),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_wdata_o   (s_wdata_o),
        .s_be_o      (s_be_o),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .s_err_i     (s_err_i),
        .proto_err_o (proto_err_o)
    );

    // Free-running core clock, rising edges at 5, 15, 25 ...
    initial begin
        core_clk_i = 1'b0;
        forever #5 core_clk_i = ~core_clk_i;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic modelReset();
        mRr      = 0;
        mLock    = 1'b0;
        mLockIdx = 0;
        mQ.delete();
        mProto   = 1'b0;
        holdReq  = '0;
    endtask

    task automatic setMgr(input int i, input logic req, input logic [AW-1:0] addr,
                          input logic we, input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        m_req_i[i]   = req;
        m_addr_i[i]  = addr;
        m_we_i[i]    = we;
        m_wdata_i[i] = wdata;
        m_be_i[i]    = be;
    endtask

    task automatic applyStimulus(input logic gnt, input logic rvalid,
                                 input logic [DW-1:0] rdata, input logic err);
        s_gnt_i    = gnt;
        s_rvalid_i = rvalid;
        s_rdata_i  = rdata;
        s_err_i    = err;
    endtask

    // Compare every DUT output against the model for the current cycle, then advance the model.
    task automatic checkOutput();
        int sel;
        bit expSReq;
        logic [NM-1:0] expGnt;
        logic [NM-1:0] expRv;
        logic [NM-1:0] expErr;
        if (mLock) begin
            sel = mLockIdx;
        end else begin
            sel = mRr;
            for (int k = 0; k < NM; k++) begin
                if (m_req_i[(mRr + k) % NM]) begin
                    sel = (mRr + k) % NM;
                    break;
                end
            end
        end
        expSReq = (m_req_i != '0) && (mQ.size() < MO);
        check("s_req_o", 64'(s_req_o), 64'(expSReq));
        if (expSReq) begin
            check("s_addr_o", 64'(s_addr_o), 64'(m_addr_i[sel]));
            check("s_we_o", 64'(s_we_o), 64'(m_we_i[sel]));
            check("s_wdata_o", 64'(s_wdata_o), 64'(m_wdata_i[sel]));
            check("s_be_o", 64'(s_be_o), 64'(m_be_i[sel]));
        end
        expGnt = '0;
        if (expSReq && s_gnt_i) expGnt[sel] = 1'b1;
        check("m_gnt_o", 64'(m_gnt_o), 64'(expGnt));
        expRv  = '0;
        expErr = '0;
        if (s_rvalid_i && mQ.size() > 0) begin
            expRv[mQ[0]]  = 1'b1;
            expErr[mQ[0]] = s_err_i;
        end
        check("m_rvalid_o", 64'(m_rvalid_o), 64'(expRv));
        check("m_err_o", 64'(m_err_o), 64'(expErr));
        for (int i = 0; i < NM; i++) begin
            if (expRv[i]) check("m_rdata_o", 64'(m_rdata_o[i]), 64'(s_rdata_i));
        end
        check("proto_err_o", 64'(proto_err_o), 64'(mProto));

        if (s_rvalid_i) begin
            if (mQ.size() > 0) void'(mQ.pop_front());
            else mProto = 1'b1;
        end
        if (expGnt != '0) begin
            mQ.push_back(sel);
            mRr   = (sel + 1) % NM;
            mLock = 1'b0;
        end else if (expSReq) begin
            mLock    = 1'b1;
            mLockIdx = sel;
        end
        holdReq = m_req_i & ~expGnt;
    endtask

    task automatic endCycle();
        checkOutput();
        @(posedge core_clk_i);
        #1;
    endtask

    // Random traffic that keeps an ungranted address phase stable, as OBI managers must.
    task automatic randomCycle(input bit drain);
        for (int i = 0; i < NM; i++) begin
            if (!holdReq[i]) begin
                if (drain) setMgr(i, 1'b0, '0, 1'b0, '0, '0);
                else setMgr(i, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                            $urandom, BW'($urandom_range(0, 15)));
            end
        end
        applyStimulus(drain ? 1'b1 : 1'($urandom_range(0, 1)),
                      (mQ.size() > 0) && (drain || ($urandom_range(0, 1) == 1)),
                      $urandom, 1'($urandom_range(0, 1)));
        #3;
        endCycle();
    endtask

    initial begin
        int guard;
        // Reset with activity on every input: all strobes must stay low.
        rstn_i = 1'b0;
        setMgr(0, 1'b1, 32'h200, 1'b0, '0, '1);
        setMgr(1, 1'b1, 32'h100, 1'b0, '0, '1);
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1);
        #3;
        check("reset_s_req", 64'(s_req_o), 64'd0);
        check("reset_gnt", 64'(m_gnt_o), 64'd0);
        check("reset_rvalid", 64'(m_rvalid_o), 64'd0);
        check("reset_err", 64'(m_err_o), 64'd0);
        check("reset_proto", 64'(proto_err_o), 64'd0);
        modelReset();
        @(posedge core_clk_i);
        @(posedge core_clk_i);
        #1;
        rstn_i = 1'b1;

        // Single read from manager 1.
        setMgr(0, 1'b0, '0, 1'b0, '0, '0);
        setMgr(1, 1'b1, 32'h0000_0010, 1'b0, '0, 4'hF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        #3;
        check("single_addr", 64'(s_addr_o), 64'h10);
        check("single_gnt", 64'(m_gnt_o), 64'b10);
        endCycle();
        setMgr(1, 1'b0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #3;
        check("single_rvalid", 64'(m_rvalid_o), 64'b10);
        check("single_rdata", 64'(m_rdata_o[1]), 64'hDEAD_BEEF);
        endCycle();

        // Contention: grants alternate, responses follow grant order one cycle later.
        for (int k = 0; k < 5; k++) begin
            setMgr(0, k < 4, 32'hA000 + 32'(k), 1'b0, '0, 4'hF);
            setMgr(1, k < 4, 32'hB000 + 32'(k), 1'b0, '0, 4'hF);
            applyStimulus(1'b1, k > 0, 32'(k), 1'b0);
            #3;
            if (k < 4) check("contend_gnt", 64'(m_gnt_o), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k > 0) check("contend_rvalid", 64'(m_rvalid_o), (k % 2 == 1) ? 64'b01 : 64'b10);
            endCycle();
        end

        // Stall lock: manager 1 stalled, manager 0 joins but cannot preempt.
        for (int k = 0; k < 6; k++) begin
            setMgr(0, (k >= 1) && (k <= 4), 32'h200, 1'b0, '0, 4'hF);
            setMgr(1, k <= 3, 32'h100, 1'b0, '0, 4'hF);
            applyStimulus((k == 3) || (k == 4), k >= 4, 32'h55 + 32'(k), 1'b0);
            #3;
            if (k <= 3) check("lock_addr", 64'(s_addr_o), 64'h100);
            if (k <= 2) check("lock_nogrant", 64'(m_gnt_o), 64'b00);
            if (k == 3) check("lock_first_gnt", 64'(m_gnt_o), 64'b10);
            if (k == 4) check("lock_second_gnt", 64'(m_gnt_o), 64'b01);
            endCycle();
        end

        // Full FIFO: two outstanding block further requests until a response is consumed.
        for (int k = 0; k < 6; k++) begin
            setMgr(0, k <= 4, 32'h300 + 32'(k), 1'b0, '0, 4'hF);
            setMgr(1, 1'b0, '0, 1'b0, '0, '0);
            applyStimulus(k != 3, (k == 2) || (k >= 4), 32'h77, 1'b0);
            #3;
            if (k == 2) check("full_blocked", 64'(s_req_o), 64'd0);
            if (k == 3) check("full_reopened", 64'(s_req_o), 64'd1);
            endCycle();
        end

        // Error routing on a manager 0 write.
        setMgr(0, 1'b1, 32'h400, 1'b1, 32'hCAFE_F00D, 4'b0011);
        setMgr(1, 1'b0, '0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        #3;
        check("err_wr_be", 64'(s_be_o), 64'b0011);
        check("err_wr_we", 64'(s_we_o), 64'd1);
        endCycle();
        setMgr(0, 1'b0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        #3;
        check("err_route_err", 64'(m_err_o), 64'b01);
        check("err_route_rvalid", 64'(m_rvalid_o), 64'b01);
        endCycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) randomCycle(1'b0);
        guard = 0;
        while (((mQ.size() > 0) || (holdReq != '0)) && guard < 100) begin
            randomCycle(1'b1);
            guard++;
        end
        if (guard >= 100) begin
            checkCount++;
            $display("[TB] FAIL drain_timeout: got %0d outstanding, expected 0", mQ.size());
        end

        // Reset mid-operation with two transactions outstanding.
        for (int k = 0; k < 2; k++) begin
            setMgr(0, 1'b1, 32'h500, 1'b0, '0, 4'hF);
            setMgr(1, 1'b1, 32'h600, 1'b0, '0, 4'hF);
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            #3;
            endCycle();
        end
        applyStimulus(1'b1, 1'b1, 32'h99, 1'b1);
        #3;
        rstn_i = 1'b0;
        #1;
        check("midreset_s_req", 64'(s_req_o), 64'd0);
        check("midreset_gnt", 64'(m_gnt_o), 64'd0);
        check("midreset_rvalid", 64'(m_rvalid_o), 64'd0);
        check("midreset_err", 64'(m_err_o), 64'd0);
        modelReset();
        @(posedge core_clk_i);
        #1;
        rstn_i = 1'b1;
        setMgr(0, 1'b0, '0, 1'b0, '0, '0);
        setMgr(1, 1'b0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 32'h42, 1'b0);
        #3;
        check("spurious_rvalid", 64'(m_rvalid_o), 64'd0);
        endCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        #3;
        check("spurious_proto", 64'(proto_err_o), 64'd1);
        endCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI subordinate port (the core-side port of the dual-port RAM) between NumMgr OBI managers, e.g. instruction fetch and data load/store.
- Grants are round-robin.
- Every accepted address phase is tagged with its manager index in an in-order ID FIFO, which routes each response back to its owner.
- Sits between core-side requesters and the RAM in the single core clock domain.

Parameters:
- NumMgr, 2, number of requesting managers (≥2).
- AddrWidth, 32, address width in bits.
- DataWidth, 32, data width in bits; byte-enable width is DataWidth/8.
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (≥1).
- IdxWidth (localparam), $clog2(NumMgr), manager index width.

Ports:
- core_clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- m_req_i  in  [NumMgr]  per-manager address-phase request.
- m_gnt_o  out  [NumMgr]  per-manager grant.
- m_addr_i  in  [NumMgr][AddrWidth]  per-manager address.
- m_we_i  in  [NumMgr]  write enable (1 write, 0 read).
- m_wdata_i  in  [NumMgr][DataWidth]  write data.
- m_be_i  in  [NumMgr][DataWidth/8]  byte enables.
- m_rvalid_o  out  [NumMgr]  response valid, one-hot or zero.
- m_rdata_o  out  [NumMgr][DataWidth]  read data, broadcast to all managers.
- m_err_o  out  [NumMgr]  error response, qualified by m_rvalid_o.
- s_req_o  out  1  subordinate request.
- s_gnt_i  in  1  subordinate grant.
- s_addr_o  out  AddrWidth  forwarded address.
- s_we_o  out  1  forwarded write enable.
- s_wdata_o  out  DataWidth  forwarded write data.
- s_be_o  out  DataWidth/8  forwarded byte enables.
- s_rvalid_i  in  1  subordinate response valid.
- s_rdata_i  in  DataWidth  subordinate read data.
- s_err_i  in  1  subordinate error.
- proto_err_o  out  1  sticky flag: response received with no outstanding transaction.

Behaviour:
- Reset (async assert, sync release): rr pointer = 0, lock cleared, FIFO empty, proto_err_o = 0.
  - All outputs are 0 during reset; address outputs reflect the selected (or 0) manager.
  - Outstanding transactions are discarded; responses arriving after reset set proto_err_o.
- Selection (combinational): first requesting manager at or after rr pointer, wrapping modulo NumMgr.
  - If lock_q is set, selection is forced to lock_idx_q.
- s_req_o = (any m_req_i) && (count < MaxOutstanding).
  - Gating ignores a same-cycle pop, so the full-FIFO decision is deterministic.
- s_addr_o / s_we_o / s_wdata_o / s_be_o = selected manager's fields.
- Grant: m_gnt_o[sel] = s_req_o && s_gnt_i; all other grants are 0.
- Lock: if s_req_o && !s_gnt_i, set lock_q and lock_idx_q = sel next cycle.
  - This keeps the OBI address phase stable; a higher-rr-priority request cannot preempt.
  - Lock clears on handshake.
- Handshake (s_req_o && s_gnt_i):
  - Push sel into the FIFO.
  - rr pointer <= (sel+1) mod NumMgr, wrapping at NumMgr-1.
- Response: subordinate responds no earlier than the cycle after the handshake, in order.
  - If s_rvalid_i && count>0: m_rvalid_o[head] = 1, m_err_o[head] = s_err_i; pop.
  - m_rdata_o = s_rdata_i for all managers.
- Spurious response (s_rvalid_i && count==0): no m_rvalid_o; proto_err_o <= 1 until reset.
- Simultaneous push and pop: count unchanged; head advances; new tail written.
- Latency: zero added cycles on both request and response paths (pure combinational forwarding); state updates on the clock edge only.

Decomposition:
- No new shared-package typedefs; widths derive from parameters.
- One sub-module, obi_id_fifo: synchronous FIFO, depth MaxOutstanding, width IdxWidth.
  - Ports: push, pop, din, head, count.
  - Async active-low reset.
  - Wrap-around read/write pointers; push on full is illegal (assertion).

Test Plan:
- Single read: m_req_i[1]=1, addr 0x0000_0010, s_gnt_i=1 → s_addr_o=0x10, m_gnt_o=2'b10 same cycle. Next cycle s_rvalid_i=1, s_rdata_i=0xDEADBEEF → m_rvalid_o=2'b10, m_rdata_o[1]=0xDEADBEEF.
- Contention: both managers request continuously, s_gnt_i=1, responses 1 cycle later → grants alternate 01,10,01,10; responses routed in the same order.
- Stall lock: rr favours manager 0, only manager 1 requests, s_gnt_i=0 for 3 cycles; manager 0 raises req in cycle 2 → s_addr_o stays manager 1's address; first grant goes to manager 1.
- Full FIFO: MaxOutstanding=2, two handshakes with no response → s_req_o=0 while m_req_i≠0. One s_rvalid_i → s_req_o=1 the next cycle, not the same cycle.
- Error routing: manager 0 write with be=4'b0011, response with s_err_i=1 → m_err_o=2'b01, m_rvalid_o=2'b01.
- Reset mid-operation: 2 outstanding, assert rstn_i=0 asynchronously → outputs 0 immediately. After release, s_rvalid_i=1 → proto_err_o=1, m_rvalid_o=0.
